// File: rtl/can_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_pkg : shared FSM state type and CAN bit-level constants        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package can_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RECEIVE   = 2'd2
  } can_state_e;

  localparam int INTEGRATE_BITS = 11;
  localparam int STUFF_LIMIT    = 5;
  localparam int EOF_IFS_BITS   = 10;

endpackage
`default_nettype wire

// File: rtl/can_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_rx_sync : 2-flop synchronizer for the CAN line plus edge detect |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module can_rx_sync (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx_Serial,
  output logic o_Rx,
  output logic o_Edge,
  output logic o_Fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_Rx_Serial;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Recessive reset value keeps a held-recessive line from looking like an edge.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_Rx   = sync_q;
  assign o_Edge = sync_q ^ prev_q;
  assign o_Fall = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/can_bit_destuff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_bit_destuff : CAN bit timing, bus integration and destuffing   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx_Serial,
  input  logic i_Stuff_En,
  output logic o_Bit,
  output logic o_Bit_Valid,
  output logic o_Sof,
  output logic o_Stuff_Err,
  output logic o_Bus_Idle
);

  localparam int             PW        = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0]  PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0]  PH_SAMPLE = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0]  PH_ONE    = PW'(1);
  localparam logic [3:0]     INT_LAST  = 4'(INTEGRATE_BITS - 1);
  localparam logic [2:0]     RUN_STUFF = 3'(STUFF_LIMIT);
  localparam logic [3:0]     EOF_LAST  = 4'(EOF_IFS_BITS - 1);

  logic rx, rx_edge, rx_fall;

  can_rx_sync u_sync (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx        (rx),
    .o_Edge      (rx_edge),
    .o_Fall      (rx_fall)
  );

  can_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    int_cnt_q, int_cnt_d;
  logic [2:0]    run_cnt_q, run_cnt_d;
  logic          run_val_q, run_val_d;
  logic [3:0]    rec_cnt_q, rec_cnt_d;
  logic          first_q, first_d;
  logic          stuff_en_q, stuff_en_d;
  logic          bit_q, bit_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          err_q, err_d;

  logic sample_pt, rx_sample, stuff_slot, stuff_viol, deliver, eof_done, int_done;

  assign sample_pt  = (phase_q == PH_SAMPLE);
  assign rx_sample  = (state_q == ST_RECEIVE) && sample_pt;
  assign stuff_slot = rx_sample && !first_q && i_Stuff_En && (run_cnt_q == RUN_STUFF);
  assign stuff_viol = stuff_slot && (rx == run_val_q);
  assign deliver    = rx_sample && !stuff_slot;
  assign eof_done   = rx_sample && !first_q && !i_Stuff_En && rx && (rec_cnt_q == EOF_LAST);
  assign int_done   = (state_q == ST_INTEGRATE) && sample_pt && rx && (int_cnt_q == INT_LAST);

  always_ff @(posedge i_Clock) begin : state_reg
    if (!i_Rst_n) state_q <= ST_INTEGRATE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_INTEGRATE: if (int_done) state_d = ST_IDLE;
      ST_IDLE:      if (rx_fall) state_d = ST_RECEIVE;
      ST_RECEIVE: begin
        if (stuff_viol)    state_d = ST_INTEGRATE;
        else if (eof_done) state_d = ST_IDLE;
      end
      default:      state_d = ST_INTEGRATE;
    endcase
  end

  always_comb begin : datapath_next
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
    // IDLE hard-syncs on SOF; elsewhere any edge away from the sample point resyncs.
    if ((state_q == ST_IDLE) ? rx_fall : (rx_edge && !sample_pt)) phase_d = '0;

    int_cnt_d = int_cnt_q;
    if (state_q != ST_INTEGRATE) int_cnt_d = '0;
    else if (sample_pt)          int_cnt_d = (rx && !int_done) ? int_cnt_q + 4'd1 : 4'd0;

    first_d = first_q;
    if ((state_q == ST_IDLE) && rx_fall) first_d = 1'b1;
    else if (rx_sample)                  first_d = 1'b0;

    run_cnt_d = run_cnt_q;
    run_val_d = run_val_q;
    if (rx_sample) begin
      if (first_q) begin
        run_cnt_d = 3'd1;
        run_val_d = rx;
      end else if (i_Stuff_En) begin
        if (stuff_viol) begin
          run_cnt_d = 3'd0;
        end else if (stuff_slot || (rx != run_val_q)) begin
          run_cnt_d = 3'd1;
          run_val_d = rx;
        end else begin
          run_cnt_d = run_cnt_q + 3'd1;
        end
      end
    end
    if (stuff_en_q && !i_Stuff_En) run_cnt_d = 3'd0;

    rec_cnt_d = rec_cnt_q;
    if (i_Stuff_En || (state_q != ST_RECEIVE)) rec_cnt_d = '0;
    else if (rx_sample && !first_q)            rec_cnt_d = (rx && !eof_done) ? rec_cnt_q + 4'd1 : 4'd0;

    stuff_en_d = i_Stuff_En;
  end

  always_comb begin : output_next
    bit_d   = deliver ? rx : bit_q;
    valid_d = deliver;
    sof_d   = rx_sample && first_q;
    err_d   = stuff_viol;
  end

  always_ff @(posedge i_Clock) begin : datapath_reg
    if (!i_Rst_n) begin
      phase_q    <= '0;
      int_cnt_q  <= '0;
      run_cnt_q  <= '0;
      run_val_q  <= 1'b0;
      rec_cnt_q  <= '0;
      first_q    <= 1'b0;
      stuff_en_q <= 1'b0;
      bit_q      <= 1'b1;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      int_cnt_q  <= int_cnt_d;
      run_cnt_q  <= run_cnt_d;
      run_val_q  <= run_val_d;
      rec_cnt_q  <= rec_cnt_d;
      first_q    <= first_d;
      stuff_en_q <= stuff_en_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      err_q      <= err_d;
    end
  end

  assign o_Bit       = bit_q;
  assign o_Bit_Valid = valid_q;
  assign o_Sof       = sof_q;
  assign o_Stuff_Err = err_q;
  assign o_Bus_Idle  = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: doc/can_bit_destuff.md
CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

Interface
REQ-001 CLKS_PER_BIT, default 10, system clocks per CAN bit time; legal range 4 or more.
REQ-002 i_Clock  in  1  system clock; all logic on rising edge.
REQ-003 i_Rst_n  in  1  synchronous active-low reset.
REQ-004 i_Rx_Serial  in  1  raw CAN line, asynchronous (0 = dominant, 1 = recessive).
REQ-005 i_Stuff_En  in  1  driven by downstream can_rx; 1 = SOF through CRC field (destuffing active), 0 = delimiter/ACK/EOF region.
REQ-006 o_Bit  out  1  destuffed data bit, valid while o_Bit_Valid=1.
REQ-007 o_Bit_Valid  out  1  single-cycle strobe per delivered bit.
REQ-008 o_Sof  out  1  single-cycle strobe coincident with the o_Bit_Valid of the SOF bit.
REQ-009 o_Stuff_Err  out  1  single-cycle strobe on stuff-rule violation.
REQ-010 o_Bus_Idle  out  1  level; 1 while in IDLE state.

Function
REQ-011 i_Rx_Serial SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; edge detect on the synchronized value.
REQ-012 FSM states SHALL be INTEGRATE, IDLE, RECEIVE.
REQ-013 INTEGRATE: SHALL sample at the mid-bit point; 11 consecutive recessive samples -> IDLE; any dominant sample restarts the count at 0.
REQ-014 IDLE: a synchronized falling edge SHALL hard-sync the phase counter to 0 and enter RECEIVE.
REQ-015 RECEIVE: phase counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the sample point is phase == CLKS_PER_BIT/2 (integer divide).
REQ-016 RECEIVE: every synchronized edge (either direction) outside the sample-point cycle SHALL reset the phase counter to 0 (hard resync).
REQ-017 o_Bit/o_Bit_Valid SHALL be registered one cycle after the sample-point cycle.
REQ-018 Run counter SHALL track consecutive equal sampled bits, including stuff bits; with i_Stuff_En=1, once the run reaches 5 the next sample is a stuff bit.
REQ-019 If the stuff bit differs from the run value: SHALL NOT be delivered; run resets to 1 with the stuff value.
REQ-020 If the stuff bit equals the run value: o_Stuff_Err SHALL pulse at the o_Bit_Valid timing slot, no o_Bit_Valid, FSM -> INTEGRATE.
REQ-021 With i_Stuff_En=0: every sample SHALL be delivered, run counting disabled; a 1->0 transition of i_Stuff_En clears the run counter.
REQ-022 With i_Stuff_En=0 and 10 consecutive recessive samples (7 EOF + 3 IFS), SHALL return to IDLE after delivering the 10th bit.
REQ-023 A dominant sample while i_Stuff_En=0 SHALL be delivered normally and restart the recessive count.
REQ-024 The first bit of RECEIVE (SOF) SHALL always be delivered, with o_Sof=1.

Reset
REQ-025 On i_Rst_n=0 at a rising edge: state=INTEGRATE, counters=0, synchronizer=1, o_Bit=1, o_Bit_Valid=0, o_Sof=0, o_Stuff_Err=0, o_Bus_Idle=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further strobes from the next cycle onward.

Structure
REQ-027 Package can_pkg SHALL hold the FSM state enum and the constants INTEGRATE_BITS=11, STUFF_LIMIT=5, EOF_IFS_BITS=10.
REQ-028 The synchronizer plus edge detect SHALL be a sub-module can_rx_sync; the rest of the design is flat.

Verification (CLKS_PER_BIT=10, 100 ns clock, bit = 1000 ns)
REQ-029 Reset, line held at 1 for 11 bits -> o_Bus_Idle rises after the 11th sample; all strobes 0 during reset.
REQ-030 From idle, drive 0,0,0,0,0,1(stuff),0,1 with i_Stuff_En=1 -> delivered 0,0,0,0,0,0,1 (stuff bit dropped); o_Sof on the first bit only.
REQ-031 Drive six 0s with i_Stuff_En=1 -> 5 bits delivered, then o_Stuff_Err pulses once and o_Bus_Idle stays 0 until 11 recessive bits follow.
REQ-032 Drive the 108-bit standard data frame, stuffed, with i_Stuff_En dropped after the CRC, followed by 10 recessive bits -> destuffed sequence matches the unstuffed frame bit-for-bit; o_Bus_Idle=1 afterwards.
REQ-033 Bit period stretched to 11 clocks on alternating bits -> resync keeps every sample mid-bit; no errors; correct data.
REQ-034 i_Rst_n pulsed low for 1 cycle mid-frame -> no o_Bit_Valid afterwards; o_Bus_Idle re-rises only after 11 recessive bits.
